// File: rtl/viterbi_ber_checker.sv
// BER monitor behind the Viterbi decoder: learns the end-to-end latency from a
// reference-bit history, then counts decoded bit errors and re-acquires on loss.
module viterbi_ber_checker #(
    parameter int HIST_DEPTH = 64,
    parameter int WIN        = 32,
    parameter int SYNC_THR   = 2,
    parameter int LOSS_THR   = 8,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ref_bit_i,
    input  logic                          ref_valid_i,
    input  logic                          dec_bit_i,
    input  logic                          dec_valid_i,
    input  logic                          clear_i,
    output logic                          locked_o,
    output logic [$clog2(HIST_DEPTH)-1:0] latency_o,
    output logic [CNT_W-1:0]              bit_ct_o,
    output logic [CNT_W-1:0]              err_ct_o,
    output logic [CNT_W-1:0]              loss_ct_o,
    output logic                          err_pulse_o
);
    localparam int D_W  = $clog2(HIST_DEPTH);
    localparam int F_W  = $clog2(HIST_DEPTH + 1);
    localparam int WC_W = $clog2(WIN + 1);

    typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

    state_t              state_reg, state_next;
    logic [HIST_DEPTH-1:0] hist_reg;
    logic [F_W-1:0]      fill_reg;
    logic [D_W-1:0]      d_reg, d_next;
    logic [WC_W-1:0]     win_cnt_reg, win_cnt_next;
    logic [WC_W-1:0]     win_err_reg, win_err_next;
    logic [WC_W-1:0]     win_err_sum;
    logic [CNT_W-1:0]    bit_ct_reg, bit_ct_next;
    logic [CNT_W-1:0]    err_ct_reg, err_ct_next;
    logic [CNT_W-1:0]    loss_ct_reg, loss_ct_next;
    logic                err_pulse_reg, err_pulse_next;
    logic                mismatch;

    // Tap reads the pre-shift history, so a same-cycle reference bit is not seen.
    assign mismatch = dec_bit_i ^ hist_reg[d_reg];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (ref_valid_i) begin
            hist_reg <= {hist_reg[HIST_DEPTH-2:0], ref_bit_i};
            if (fill_reg != F_W'(HIST_DEPTH))
                fill_reg <= fill_reg + F_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            d_reg         <= '0;
            win_cnt_reg   <= '0;
            win_err_reg   <= '0;
            bit_ct_reg    <= '0;
            err_ct_reg    <= '0;
            loss_ct_reg   <= '0;
            err_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            d_reg         <= d_next;
            win_cnt_reg   <= win_cnt_next;
            win_err_reg   <= win_err_next;
            bit_ct_reg    <= bit_ct_next;
            err_ct_reg    <= err_ct_next;
            loss_ct_reg   <= loss_ct_next;
            err_pulse_reg <= err_pulse_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        d_next         = d_reg;
        win_cnt_next   = win_cnt_reg;
        win_err_next   = win_err_reg;
        win_err_sum    = win_err_reg + WC_W'(mismatch);
        bit_ct_next    = bit_ct_reg;
        err_ct_next    = err_ct_reg;
        loss_ct_next   = loss_ct_reg;
        err_pulse_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (fill_reg == F_W'(HIST_DEPTH))
                    state_next = SEARCH;
            end
            SEARCH, LOCKED: begin
                if (dec_valid_i) begin
                    if (state_reg == LOCKED) begin
                        if (bit_ct_reg != '1)
                            bit_ct_next = bit_ct_reg + CNT_W'(1);
                        if (mismatch && err_ct_reg != '1)
                            err_ct_next = err_ct_reg + CNT_W'(1);
                        err_pulse_next = mismatch;
                    end
                    if (win_cnt_reg == WC_W'(WIN - 1)) begin
                        win_cnt_next = '0;
                        win_err_next = '0;
                        if (state_reg == SEARCH) begin
                            if (win_err_sum <= WC_W'(SYNC_THR))
                                state_next = LOCKED;
                            else
                                d_next = (d_reg == D_W'(HIST_DEPTH - 1)) ? '0 : d_reg + D_W'(1);
                        end else if (win_err_sum > WC_W'(LOSS_THR)) begin
                            // Lock lost: resume searching from the delay that just failed.
                            state_next = SEARCH;
                            if (loss_ct_reg != '1)
                                loss_ct_next = loss_ct_reg + CNT_W'(1);
                        end
                    end else begin
                        win_cnt_next = win_cnt_reg + WC_W'(1);
                        win_err_next = win_err_sum;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (clear_i) begin
            bit_ct_next  = '0;
            err_ct_next  = '0;
            loss_ct_next = '0;
        end
    end

    assign locked_o    = (state_reg == LOCKED);
    assign latency_o   = d_reg;
    assign bit_ct_o    = bit_ct_reg;
    assign err_ct_o    = err_ct_reg;
    assign loss_ct_o   = loss_ct_reg;
    assign err_pulse_o = err_pulse_reg;
endmodule
